// File: rtl/lut_arbiter.sv
// lut_arbiter: two-requester round-robin arbiter and sequencer for the shared
// 64 x 64-bit coefficient LUT (combinational ROM, Q9.55 data).
//
// One lookup is in flight at a time. The winner's address is registered onto
// lut_addr_o, the LUT output is registered into resp_data_o one cycle later,
// and the response is held on the winner's response channel until it is
// consumed. Priority flips to the other requester after each delivered
// response.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   req0_valid_i   requester 0 lookup pending
//   req0_addr_i    requester 0 LUT address
//   req0_ready_o   requester 0 request accepted this cycle
//   req1_valid_i   requester 1 lookup pending
//   req1_addr_i    requester 1 LUT address
//   req1_ready_o   requester 1 request accepted this cycle
//   resp0_valid_o  response for requester 0 valid
//   resp1_valid_o  response for requester 1 valid
//   resp_data_o    registered LUT data, shared by both responses
//   resp0_ready_i  requester 0 consumes its response
//   resp1_ready_i  requester 1 consumes its response
//   lut_addr_o     registered LUT address
//   lut_dout_i     LUT read data (combinational from lut_addr_o)
//   busy_o         high whenever the sequencer is not idle
module lut_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  output logic              req1_ready_o,
  output logic              resp0_valid_o,
  output logic              resp1_valid_o,
  output logic [DATA_W-1:0] resp_data_o,
  input  logic              resp0_ready_i,
  input  logic              resp1_ready_i,
  output logic [ADDR_W-1:0] lut_addr_o,
  input  logic [DATA_W-1:0] lut_dout_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {StIdle, StLookup, StResp} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              id_q, id_d;
  logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  logic any_valid;
  logic winner;
  logic req_hs;
  logic resp_hs;

  // A lone requester wins outright; prio only breaks ties.
  assign any_valid = req0_valid_i | req1_valid_i;
  assign winner    = (req0_valid_i & req1_valid_i) ? prio_q : req1_valid_i;
  assign req_hs    = (state_q == StIdle) & any_valid;
  // Only the granted requester's resp_ready is looked at.
  assign resp_hs   = (state_q == StResp) & (id_q ? resp1_ready_i : resp0_ready_i);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      lut_addr_q  <= '0;
      resp_data_q <= '0;
    end else begin
      prio_q      <= prio_d;
      id_q        <= id_d;
      lut_addr_q  <= lut_addr_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    id_d        = id_q;
    lut_addr_d  = lut_addr_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      StIdle: begin
        if (req_hs) begin
          state_d    = StLookup;
          id_d       = winner;
          lut_addr_d = winner ? req1_addr_i : req0_addr_i;
        end
      end
      StLookup: begin
        state_d     = StResp;
        resp_data_d = lut_dout_i;
      end
      StResp: begin
        if (resp_hs) begin
          state_d = StIdle;
          prio_d  = ~id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: response valids and busy decode registered state only.
  always_comb begin
    req0_ready_o  = req_hs & ~winner;
    req1_ready_o  = req_hs & winner;
    resp0_valid_o = (state_q == StResp) & ~id_q;
    resp1_valid_o = (state_q == StResp) & id_q;
    busy_o        = (state_q != StIdle);
  end

  assign lut_addr_o  = lut_addr_q;
  assign resp_data_o = resp_data_q;

endmodule

// File: tb/tb_lut_arbiter.sv
// Directed bench for lut_arbiter: a per-cycle vector table for the single
// request and contention cases, then hand-written cycle sequences for
// backpressure, priority update, mid-lookup reset and boundary addresses.
module tb_lut_arbiter;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 64;

  logic              clk;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic              req0_ready, req1_ready;
  logic              resp0_valid, resp1_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp0_ready, resp1_ready;
  logic [ADDR_W-1:0] lut_addr;
  logic [DATA_W-1:0] lut_dout;
  logic              busy;

  int unsigned n_total;
  int unsigned n_pass;

  // ROM image of the coefficient LUT; entry 0 is non-zero on purpose.
  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    return (64'(a) + 64'd1) * 64'h9E37_79B9_7F4A_7C15;
  endfunction

  assign lut_dout = rom_f(lut_addr);

  lut_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (req0_valid),
    .req0_addr_i  (req0_addr),
    .req0_ready_o (req0_ready),
    .req1_valid_i (req1_valid),
    .req1_addr_i  (req1_addr),
    .req1_ready_o (req1_ready),
    .resp0_valid_o(resp0_valid),
    .resp1_valid_o(resp1_valid),
    .resp_data_o  (resp_data),
    .resp0_ready_i(resp0_ready),
    .resp1_ready_i(resp1_ready),
    .lut_addr_o   (lut_addr),
    .lut_dout_i   (lut_dout),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              v0;
    logic [ADDR_W-1:0] a0;
    logic              v1;
    logic [ADDR_W-1:0] a1;
    logic              rr0;
    logic              rr1;
    logic              e_rdy0;
    logic              e_rdy1;
    logic              e_rv0;
    logic              e_rv1;
    logic              e_busy;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v0, input int a0, input logic v1,
                              input int a1, input logic rr0, input logic rr1,
                              input logic rdy0, input logic rdy1, input logic rv0,
                              input logic rv1, input logic bsy, input int addr,
                              input logic [DATA_W-1:0] data);
    vec_t v;
    v.rst    = r;
    v.v0     = v0;
    v.a0     = ADDR_W'(a0);
    v.v1     = v1;
    v.a1     = ADDR_W'(a1);
    v.rr0    = rr0;
    v.rr1    = rr1;
    v.e_rdy0 = rdy0;
    v.e_rdy1 = rdy1;
    v.e_rv0  = rv0;
    v.e_rv1  = rv1;
    v.e_busy = bsy;
    v.e_addr = ADDR_W'(addr);
    v.e_data = data;
    return v;
  endfunction

  task automatic check(input string tag, input string field, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s.%s got %h expected %h", tag, field, act, exp);
    end
  endtask

  // Drive one cycle's inputs, compare outputs mid-cycle, then advance past the edge.
  task automatic run_vec(input string tag, input vec_t v);
    rst         = v.rst;
    req0_valid  = v.v0;
    req0_addr   = v.a0;
    req1_valid  = v.v1;
    req1_addr   = v.a1;
    resp0_ready = v.rr0;
    resp1_ready = v.rr1;
    #1;
    check(tag, "req0_ready", 64'(req0_ready), 64'(v.e_rdy0));
    check(tag, "req1_ready", 64'(req1_ready), 64'(v.e_rdy1));
    check(tag, "resp0_valid", 64'(resp0_valid), 64'(v.e_rv0));
    check(tag, "resp1_valid", 64'(resp1_valid), 64'(v.e_rv1));
    check(tag, "busy", 64'(busy), 64'(v.e_busy));
    check(tag, "lut_addr", 64'(lut_addr), 64'(v.e_addr));
    check(tag, "resp_data", resp_data, v.e_data);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    n_total     = 0;
    n_pass      = 0;
    rst         = 1'b1;
    req0_valid  = 1'b0;
    req0_addr   = '0;
    req1_valid  = 1'b0;
    req1_addr   = '0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //           rst v0 a0  v1 a1  rr0 rr1 rdy0 rdy1 rv0 rv1 bsy addr data
    // Single request to addr 5.
    tbl.push_back(mk(0, 1,  5, 0,  0, 1, 0, 1, 0, 0, 0, 0,  0, 64'd0));
    tbl.push_back(mk(0, 0,  0, 0,  0, 1, 0, 0, 0, 0, 0, 1,  5, 64'd0));
    tbl.push_back(mk(0, 0,  0, 0,  0, 1, 0, 0, 0, 1, 0, 1,  5, rom_f(5)));
    tbl.push_back(mk(0, 0,  0, 0,  0, 1, 0, 0, 0, 0, 0, 0,  5, rom_f(5)));
    // Reset so contention starts from prio=0.
    tbl.push_back(mk(1, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  5, rom_f(5)));
    // Contention: both valid, responses always ready -> 0,1,0,1 grants.
    tbl.push_back(mk(0, 1, 10, 1, 20, 1, 1, 1, 0, 0, 0, 0,  0, 64'd0));
    tbl.push_back(mk(0, 1, 10, 1, 20, 1, 1, 0, 0, 0, 0, 1, 10, 64'd0));
    tbl.push_back(mk(0, 1, 10, 1, 20, 1, 1, 0, 0, 1, 0, 1, 10, rom_f(10)));
    tbl.push_back(mk(0, 1, 10, 1, 20, 1, 1, 0, 1, 0, 0, 0, 10, rom_f(10)));
    tbl.push_back(mk(0, 1, 10, 1, 20, 1, 1, 0, 0, 0, 0, 1, 20, rom_f(10)));
    tbl.push_back(mk(0, 1, 10, 1, 20, 1, 1, 0, 0, 0, 1, 1, 20, rom_f(20)));
    tbl.push_back(mk(0, 1, 10, 1, 20, 1, 1, 1, 0, 0, 0, 0, 20, rom_f(20)));
    tbl.push_back(mk(0, 1, 10, 1, 20, 1, 1, 0, 0, 0, 0, 1, 10, rom_f(20)));
    tbl.push_back(mk(0, 1, 10, 1, 20, 1, 1, 0, 0, 1, 0, 1, 10, rom_f(10)));
    tbl.push_back(mk(0, 1, 10, 1, 20, 1, 1, 0, 1, 0, 0, 0, 10, rom_f(10)));
    tbl.push_back(mk(0, 0, 10, 0, 20, 1, 1, 0, 0, 0, 0, 1, 20, rom_f(10)));
    tbl.push_back(mk(0, 0, 10, 0, 20, 1, 1, 0, 0, 0, 1, 1, 20, rom_f(20)));
    tbl.push_back(mk(0, 0,  0, 0,  0, 1, 1, 0, 0, 0, 0, 0, 20, rom_f(20)));

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec($sformatf("tbl%0d", i), tbl[i]);
    end

    // Backpressure: resp1 stalled 5 cycles; req0 waits, resp0_ready is ignored.
    run_vec("bp_acc", mk(0, 0, 7, 1, 63, 1, 0, 0, 1, 0, 0, 0, 20, rom_f(20)));
    run_vec("bp_lkp", mk(0, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1, 63, rom_f(20)));
    for (int i = 0; i < 5; i++) begin
      run_vec($sformatf("bp_hold%0d", i),
              mk(0, 1, 7, 0, 0, 1, 0, 0, 0, 0, 1, 1, 63, rom_f(63)));
    end
    run_vec("bp_hs",   mk(0, 1, 7, 0, 0, 1, 1, 0, 0, 0, 1, 1, 63, rom_f(63)));
    run_vec("bp_acc0", mk(0, 1, 7, 0, 0, 1, 1, 1, 0, 0, 0, 0, 63, rom_f(63)));
    run_vec("bp_lkp0", mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1,  7, rom_f(63)));
    run_vec("bp_rsp0", mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 1,  7, rom_f(7)));

    // Priority update: prio=1 now; serve req1 alone, then both -> req0 wins.
    run_vec("pu_acc1", mk(0, 0,  0, 1,  1, 1, 1, 0, 1, 0, 0, 0,  7, rom_f(7)));
    run_vec("pu_lkp1", mk(0, 0,  0, 0,  0, 1, 1, 0, 0, 0, 0, 1,  1, rom_f(7)));
    run_vec("pu_rsp1", mk(0, 0,  0, 0,  0, 1, 1, 0, 0, 0, 1, 1,  1, rom_f(1)));
    run_vec("pu_both", mk(0, 1, 40, 1, 41, 1, 1, 1, 0, 0, 0, 0,  1, rom_f(1)));
    run_vec("pu_lkp0", mk(0, 0,  0, 0,  0, 1, 1, 0, 0, 0, 0, 1, 40, rom_f(1)));
    run_vec("pu_rsp0", mk(0, 0,  0, 0,  0, 1, 1, 0, 0, 1, 0, 1, 40, rom_f(40)));

    // Reset during LOOKUP of addr 33 (prio=1 beforehand).
    run_vec("rm_acc",  mk(0, 1, 33, 0,  0, 1, 1, 1, 0, 0, 0, 0, 40, rom_f(40)));
    run_vec("rm_lkp",  mk(1, 0,  0, 0,  0, 1, 1, 0, 0, 0, 0, 1, 33, rom_f(40)));
    run_vec("rm_post", mk(0, 0,  0, 0,  0, 1, 1, 0, 0, 0, 0, 0,  0, 64'd0));
    run_vec("rm_idle", mk(0, 0,  0, 0,  0, 1, 1, 0, 0, 0, 0, 0,  0, 64'd0));

    // Boundary addresses 0 and 63; both valid also shows prio was reset to 0.
    run_vec("bd_both", mk(0, 1,  0, 1, 63, 1, 1, 1, 0, 0, 0, 0,  0, 64'd0));
    run_vec("bd_lkp0", mk(0, 0,  0, 1, 63, 1, 1, 0, 0, 0, 0, 1,  0, 64'd0));
    run_vec("bd_rsp0", mk(0, 0,  0, 1, 63, 1, 1, 0, 0, 1, 0, 1,  0, rom_f(0)));
    run_vec("bd_acc1", mk(0, 0,  0, 1, 63, 1, 1, 0, 1, 0, 0, 0,  0, rom_f(0)));
    run_vec("bd_lkp1", mk(0, 0,  0, 0,  0, 1, 1, 0, 0, 0, 0, 1, 63, rom_f(0)));
    run_vec("bd_rsp1", mk(0, 0,  0, 0,  0, 1, 1, 0, 0, 0, 1, 1, 63, rom_f(63)));
    run_vec("bd_idle", mk(0, 0,  0, 0,  0, 1, 1, 0, 0, 0, 0, 0, 63, rom_f(63)));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
